// File: rtl/dec_pkg.sv
// Shared opcode encodings, FSM state type and bank helper for the dec_scan select decoder.
package dec_pkg;

    localparam logic [1:0] DEC_OP_LOAD  = 2'b00;
    localparam logic [1:0] DEC_OP_SCAN  = 2'b01;
    localparam logic [1:0] DEC_OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } dec_state_t;

    // Bank number of a line index: the top log2(banks) bits of the index.
    function automatic int unsigned dec_bank_of(input int unsigned idx,
                                                input int unsigned idx_w,
                                                input int unsigned banks);
        if (banks <= 1) begin
            return 0;
        end
        return idx >> (idx_w - $clog2(banks));
    endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational index to one-hot decoder with enable; all-zero output when disabled.
module dec_onehot #(
    parameter int IDX_W = 8
) (
    input  logic                  en_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [2**IDX_W-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot select decoder with LOAD/CLEAR commands and an auto-increment scan.
// The scan sequencer exists only when DEC_SCAN_EN is defined; otherwise SCAN behaves as LOAD.
//
// state   | meaning
// IDLE    | no line selected
// HOLD    | one line selected and held until the next accepted command
// SCAN    | stepping one line per cycle; rem_q counts steps left after the current one
module dec_scan
    import dec_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int BANKS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [IDX_W-1:0]      cmd_idx,
    input  logic [IDX_W-1:0]      cmd_len,
    output logic [2**IDX_W-1:0]   select,
    output logic                  sel_valid,
    output logic [IDX_W-1:0]      sel_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int N      = 2**IDX_W;
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    dec_state_t          state_q;
    logic [N-1:0]        select_q;
    logic                sel_valid_q;
    logic [IDX_W-1:0]    sel_idx_q;

    logic                accept;
    logic                line_en_d;
    logic [IDX_W-1:0]    line_idx_d;
    logic [N-1:0]        line_onehot;

    // Bank of the live line, kept so a probe can see which bank is active.
    logic [BANK_W-1:0]   unused_sel_bank;
    assign unused_sel_bank = BANK_W'(dec_bank_of(32'(sel_idx_q), IDX_W, BANKS));

`ifdef DEC_SCAN_EN
    logic                busy_q;
    logic                done_q;
    logic [IDX_W-1:0]    rem_q;

    assign cmd_ready = (state_q != ST_SCAN);
    assign busy      = busy_q;
    assign done      = done_q;
`else
    logic                unused_cmd_len;

    assign unused_cmd_len = ^cmd_len;
    assign cmd_ready      = 1'b1;
    assign busy           = 1'b0;
    assign done           = 1'b0;
`endif

    assign accept    = cmd_valid && cmd_ready;
    assign select    = select_q;
    assign sel_valid = sel_valid_q;
    assign sel_idx   = sel_idx_q;

    // Next line to drive; default keeps a held line and clears anything else.
    always_comb begin
        line_en_d  = (state_q == ST_HOLD);
        line_idx_d = line_en_d ? sel_idx_q : '0;
        if (accept) begin
            case (cmd_op)
                DEC_OP_LOAD, DEC_OP_SCAN: begin
                    line_en_d  = 1'b1;
                    line_idx_d = cmd_idx;
                end
                default: begin
                    line_en_d  = 1'b0;
                    line_idx_d = '0;
                end
            endcase
        end
`ifdef DEC_SCAN_EN
        else if (state_q == ST_SCAN && rem_q != '0) begin
            line_en_d  = 1'b1;
            line_idx_d = sel_idx_q + IDX_W'(1);
        end
`endif
    end

    dec_onehot #(
        .IDX_W (IDX_W)
    ) u_onehot (
        .en_i     (line_en_d),
        .idx_i    (line_idx_d),
        .onehot_o (line_onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            select_q    <= '0;
            sel_valid_q <= 1'b0;
            sel_idx_q   <= '0;
`ifdef DEC_SCAN_EN
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rem_q       <= '0;
`endif
        end else begin
            select_q    <= line_onehot;
            sel_valid_q <= line_en_d;
            sel_idx_q   <= line_idx_d;
`ifdef DEC_SCAN_EN
            done_q      <= 1'b0;
`endif
            if (accept) begin
                case (cmd_op)
                    DEC_OP_LOAD: state_q <= ST_HOLD;
                    DEC_OP_SCAN: begin
`ifdef DEC_SCAN_EN
                        state_q <= ST_SCAN;
                        busy_q  <= 1'b1;
                        rem_q   <= cmd_len;
                        done_q  <= (cmd_len == '0);
`else
                        state_q <= ST_HOLD;
`endif
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
`ifdef DEC_SCAN_EN
            else if (state_q == ST_SCAN) begin
                if (rem_q == '0) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    rem_q  <= rem_q - IDX_W'(1);
                    done_q <= (rem_q == IDX_W'(1));
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench for dec_scan (IDX_W=8, BANKS=2); scan scenarios run when DEC_SCAN_EN is defined.
module tb_dec_scan;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SCAN  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [7:0]   cmd_idx = 8'h00;
    logic [7:0]   cmd_len = 8'h00;
    logic [255:0] select;
    logic         sel_valid;
    logic [7:0]   sel_idx;
    logic         busy;
    logic         done;

    typedef struct {
        bit       en;
        bit [7:0] idx;
        bit       busy;
        bit       done;
        bit       rdy;
        string    tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dec_scan #(
        .IDX_W (8),
        .BANKS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .cmd_len   (cmd_len),
        .select    (select),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input bit v, input bit [1:0] op, input bit [7:0] idx, input bit [7:0] len,
                       input bit r, input bit e_en, input bit [7:0] e_idx, input bit e_busy,
                       input bit e_done, input bit e_rdy, input string tag);
        exp_t e;
        @(negedge clk);
        rst       = r;
        cmd_valid = v;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_len   = len;
        e.en   = e_en;
        e.idx  = e_idx;
        e.busy = e_busy;
        e.done = e_done;
        e.rdy  = e_rdy;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit e_en, input bit [7:0] e_idx, input string tag);
        cyc(1'b0, OP_LOAD, 8'h00, 8'h00, 1'b0, e_en, e_idx, 1'b0, 1'b0, 1'b1, tag);
    endtask

    // Monitor: one expected record per clock edge once stimulus starts.
    initial begin
        exp_t         e;
        logic [255:0] one;
        logic [255:0] want;
        one = 256'd1;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                want = e.en ? (one << e.idx) : 256'd0;
                chk({e.tag, " select"},    select,    want);
                chk({e.tag, " sel_valid"}, 256'(sel_valid), 256'(e.en));
                chk({e.tag, " sel_idx"},   256'(sel_idx),   256'(e.en ? e.idx : 8'h00));
                chk({e.tag, " busy"},      256'(busy),      256'(e.busy));
                chk({e.tag, " done"},      256'(done),      256'(e.done));
                chk({e.tag, " cmd_ready"}, 256'(cmd_ready), 256'(e.rdy));
            end
        end
    end

    initial begin
        cyc(1'b0, OP_LOAD, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "reset");
        for (int i = 0; i < 3; i++) idle(1'b0, 8'h00, "idle");

        cyc(1'b1, OP_LOAD, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "load00");
        cyc(1'b1, OP_LOAD, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, "loadFF");
        idle(1'b1, 8'hFF, "holdFF");
        cyc(1'b1, OP_LOAD, 8'h80, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, "load80");
        cyc(1'b1, OP_CLEAR, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clear");
        idle(1'b0, 8'h00, "after_clear");

        cyc(1'b1, OP_LOAD, 8'h05, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, "load05");
        cyc(1'b1, OP_RSVD, 8'h42, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "rsvd");
        cyc(1'b1, OP_LOAD, 8'h7F, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, "load7F");
        cyc(1'b1, OP_LOAD, 8'h3C, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "rst_hold");
        idle(1'b0, 8'h00, "after_rst");

`ifdef DEC_SCAN_EN
        cyc(1'b1, OP_SCAN, 8'hFE, 8'd3, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, "scanFE_0");
        cyc(1'b0, OP_LOAD, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "scanFE_1");
        cyc(1'b0, OP_LOAD, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, "scanFE_2");
        cyc(1'b0, OP_LOAD, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, "scanFE_3");
        idle(1'b0, 8'h00, "scanFE_end");

        cyc(1'b1, OP_SCAN, 8'h10, 8'd2, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, "blk_0");
        cyc(1'b1, OP_LOAD, 8'h77, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, "blk_1");
        cyc(1'b1, OP_LOAD, 8'h77, 8'h00, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, "blk_2");
        cyc(1'b1, OP_LOAD, 8'h77, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "blk_idle");
        cyc(1'b1, OP_LOAD, 8'h77, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, "blk_load");

        cyc(1'b1, OP_SCAN, 8'h10, 8'd7, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, "rscan_0");
        cyc(1'b0, OP_LOAD, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, "rscan_1");
        cyc(1'b0, OP_LOAD, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "rscan_rst");
        idle(1'b0, 8'h00, "rscan_after");

        cyc(1'b1, OP_SCAN, 8'h20, 8'd0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0, "scan1");
        cyc(1'b1, OP_SCAN, 8'h03, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "b2b_idle");
        cyc(1'b1, OP_SCAN, 8'h03, 8'hFF, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, "full_0");
        for (int i = 1; i < 256; i++) begin
            cyc(1'b0, OP_LOAD, 8'h00, 8'h00, 1'b0, 1'b1, 8'(8'h03 + i), 1'b1,
                (i == 255), 1'b0, "full");
        end
        idle(1'b0, 8'h00, "full_end");
`else
        cyc(1'b1, OP_SCAN, 8'h33, 8'd5, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, "scan_as_load");
        for (int i = 0; i < 4; i++) idle(1'b1, 8'h33, "hold33");
        cyc(1'b1, OP_SCAN, 8'hC4, 8'hFF, 1'b0, 1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, "scanC4");
        idle(1'b1, 8'hC4, "holdC4");
`endif
        cyc(1'b1, OP_CLEAR, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "final_clear");

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_scan.md
# dec_scan

Registered, parametrised one-hot select decoder with a command handshake and an optional auto-increment scan mode. It generalises the flat 8-bit-to-2×128 select decoder to any index width and bank split. It adds registered outputs, hold/clear commands and a multi-cycle scan sequencer. It sits between a controller issuing line indices and the banks of select-driven datapath elements.

## Interface
Parameters:
- IDX_W, default 8: index width; total select lines N = 2^IDX_W.
- BANKS, default 2: number of select banks, a power of two ≤ N; lines per bank L = N/BANKS.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: block accepts a command this cycle.
- cmd_op, input, 2: command opcode: 00 LOAD, 01 SCAN, 10 CLEAR, 11 reserved.
- cmd_idx, input, IDX_W: target or start index.
- cmd_len, input, IDX_W: scan length minus one.
- select, output, N: one-hot select; bank b is select[b*L +: L]; bank = cmd_idx upper log2(BANKS) bits.
- sel_valid, output, 1: select holds exactly one set bit.
- sel_idx, output, IDX_W: index of the set bit; 0 when sel_valid=0.
- busy, output, 1: scan in progress.
- done, output, 1: one-cycle pulse on the last scan step.

## Operation
- FSM states: IDLE, HOLD, SCAN. Reset state is IDLE.
- Accept: a command is accepted when cmd_valid && cmd_ready.
- cmd_ready = (state != SCAN). It depends on state only, never on cmd_valid.
- IDLE: select = 0, sel_valid = 0.
- LOAD accepted in IDLE or HOLD: state → HOLD. Next cycle, select = one-hot(cmd_idx), sel_idx = cmd_idx, sel_valid = 1.
- HOLD: select is held unchanged until the next accepted command. LOAD in HOLD retargets directly without passing through zero.
- SCAN accepted: state → SCAN, busy = 1. Internal counter rem = cmd_len.
  - Each SCAN cycle drives select = one-hot(cur), with cur starting at cmd_idx.
  - cur increments by 1 per cycle, wrapping modulo N: N-1 → 0, crossing from the top bank to bank 0.
- Scan end: the step where rem == 0 asserts done for that cycle, together with the last select. On the following cycle state → IDLE, select = 0, busy = 0.
- Scan length is cmd_len+1 cycles. cmd_len = 0 gives a single-cycle scan. cmd_len = N-1 visits every line exactly once.
- CLEAR or reserved op 11 accepted: state → IDLE. Next cycle, select = 0.
- Commands presented during SCAN are not accepted; cmd_valid is ignored and the command is not queued.

## Timing
- Latency: 1 cycle from the accept edge to select/sel_valid/sel_idx update. All outputs are registered except cmd_ready.
- Reset values: select = 0, sel_valid = 0, sel_idx = 0, busy = 0, done = 0. cmd_ready = 1 in the cycle after reset.
- Reset mid-scan: the next cycle shows all outputs at reset values, with no done pulse.
- Back-to-back: a new command may be accepted on the cycle immediately after a scan's done cycle, i.e. the first IDLE cycle.
- Invariant: select is never multi-hot in any cycle.

## Configuration
- DEC_SCAN_EN defined: SCAN is implemented as described above.
- DEC_SCAN_EN undefined:
  - op 01 behaves as LOAD and cmd_len is ignored.
  - busy and done are tied to 0, and the SCAN state and counter are absent.
  - cmd_ready is constant 1.

## Structure
- Shared package dec_pkg holds:
  - op encoding constants (DEC_OP_LOAD, DEC_OP_SCAN, DEC_OP_CLEAR);
  - the state typedef dec_state_t;
  - a function computing bank index from IDX_W/BANKS.
- One sub-module, dec_onehot: purely combinational, parameter IDX_W, index → N-bit one-hot with an enable. It is instantiated once and its output is registered in dec_scan.

## Test plan
All scenarios use IDX_W=8, BANKS=2.
- Reset, then idle 3 cycles → select = 0, sel_valid = 0, cmd_ready = 1 every cycle.
- LOAD idx=0x00, then LOAD idx=0xFF → select[0] set, then select[255] set the cycle after the second accept; no zero cycle between them; sel_idx tracks.
- SCAN idx=0xFE, len=3 → select bits 254, 255, 0, 1 on consecutive cycles; done only with bit 1; cmd_ready = 0 for those 4 cycles; then select = 0.
- LOAD presented during a scan → not accepted; the scan completes unchanged; the LOAD is accepted once cmd_ready rises.
- rst asserted on the 2nd step of SCAN idx=0x10, len=7 → next cycle all outputs 0, no done.
- op 11 with idx=0x42 while in HOLD on 0x05 → next cycle select = 0, sel_valid = 0. Separately, with DEC_SCAN_EN undefined, SCAN idx=0x33 → holds bit 51 with done never asserting.
